// File: rtl/reg_dump_reader_pkg.sv
// rtl/reg_dump_reader_pkg.sv - miniRISC common widths and dump-engine state encoding (DUMP_CHECKSUM_EN adds CSUM)
package reg_dump_reader_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_DONE = 3'd3
`ifdef DUMP_CHECKSUM_EN
    ,
    ST_CSUM = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - register-file sweep and valid/ready stream-out engine (optional DUMP_CHECKSUM_EN)
module reg_dump_reader #(
  parameter int NUM_REGS = reg_dump_reader_pkg::NUM_REGS,
  parameter int ADDR_W   = reg_dump_reader_pkg::ADDR_W,
  parameter int DATA_W   = reg_dump_reader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  import reg_dump_reader_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              hs;
  logic              at_last;

  assign hs      = out_valid & out_ready;
  assign at_last = (idx == LAST_IDX);
  assign rd_addr = idx;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  // running XOR of every value captured in this dump
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum <= '0;
    end else if (state == ST_IDLE && start) begin
      csum <= '0;
    end else if (state == ST_LOAD) begin
      csum <= csum ^ rd_data;
    end
  end
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // next-state: one LOAD/SEND pair per register, then DONE for one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: begin
        if (hs) begin
          if (!at_last) begin
            state_nxt = ST_LOAD;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            state_nxt = ST_CSUM;
`else
            state_nxt = ST_DONE;
`endif
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      ST_CSUM: if (hs) state_nxt = ST_DONE;
`endif
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // sweep index and output holding register; beat fields only change on LOAD or handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) idx <= '0;
        ST_LOAD: begin
          out_data  <= rd_data;
          out_addr  <= idx;
          out_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
`else
          out_last  <= at_last;
`endif
        end
        ST_SEND: begin
          if (hs) begin
            out_valid <= 1'b0;
            if (!at_last) begin
              idx <= idx + 1'b1;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              out_valid <= 1'b1;
              out_data  <= csum;
              out_addr  <= '0;
              out_last  <= 1'b1;
`else
              out_last  <= 1'b0;
`endif
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        ST_CSUM: begin
          if (hs) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
`endif
        ST_DONE: idx <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - randomized self-checking bench for reg_dump_reader against a register-file model
`timescale 1ns/1ps
module tb_reg_dump_reader;

  localparam int N  = 32;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef DUMP_CHECKSUM_EN
  localparam int CSUM_BEATS = 1;
`else
  localparam int CSUM_BEATS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] regs [N];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  reg_dump_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic pick_ready(input int mode, input int cnt);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cnt % 3) == 2;
    return ($urandom_range(0, 3) != 0);
  endfunction

  // mode: 0 ready always, 1 ready 0,0,1, 2 random ready
  // restart_beat: pulse start once after this many accepted beats (-1 none)
  // wb_beat: write 0xDEAD into that register right after its beat is accepted (-1 none)
  // abort_addr: assert reset while the beat at this address is presented (-1 none)
  task automatic run_dump(input int mode, input int restart_beat, input int wb_beat, input int abort_addr);
    logic [DW-1:0] snap [N];
    logic [DW-1:0] xsum;
    logic [DW-1:0] e_data;
    int            e_addr;
    logic          e_last;
    int beats, dones, cnt, done_cnt, stall_err, busy_err, idle_err, exp_beats;
    bit fin, wb_pending, restarted, aborted;
    logic          prev_v, prev_r, pl;
    logic [DW-1:0] pd;
    logic [AW-1:0] pa;

    xsum = '0;
    for (int i = 0; i < N; i++) begin
      snap[i] = regs[i];
      xsum    = xsum ^ regs[i];
    end
    exp_beats = N + CSUM_BEATS;
    beats = 0; dones = 0; cnt = 0; done_cnt = 0;
    stall_err = 0; busy_err = 0; idle_err = 0;
    fin = 0; wb_pending = 0; restarted = 0; aborted = 0;
    prev_v = 0; prev_r = 0; pl = 0; pd = '0; pa = '0;

    @(posedge clk); #1;
    start     = 1'b1;
    out_ready = pick_ready(mode, 0);

    while (!fin && !aborted && cnt < 3000) begin
      @(negedge clk);
      if (cnt > 0 && busy !== 1'b1) busy_err++;
      if (prev_v && !prev_r) begin
        if (out_valid !== 1'b1 || out_data !== pd || out_addr !== pa || out_last !== pl) stall_err++;
      end
      if (abort_addr >= 0 && out_valid && out_addr == AW'(abort_addr)) begin
        #2 rst = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_addr", out_addr, 0);
        check("abort_rd_addr", rd_addr, 0);
        check("abort_last", out_last, 0);
        check("abort_done", done, 0);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        aborted = 1;
      end else begin
        if (out_valid && out_ready) begin
          if (beats < exp_beats) begin
            e_data = (beats < N) ? snap[beats] : xsum;
            e_addr = (beats < N) ? beats : 0;
            e_last = (CSUM_BEATS != 0) ? (beats == N) : (beats == N - 1);
            check($sformatf("beat%0d_data", beats), out_data, e_data);
            check($sformatf("beat%0d_addr", beats), out_addr, e_addr);
            check($sformatf("beat%0d_last", beats), out_last, e_last);
          end
          if (beats == wb_beat) wb_pending = 1;
          beats++;
        end
        if (done) begin
          dones++;
          done_cnt = cnt;
          fin = 1;
        end
        prev_v = out_valid; prev_r = out_ready; pd = out_data; pa = out_addr; pl = out_last;
        @(posedge clk); #1;
        cnt++;
        start = 1'b0;
        if (restart_beat >= 0 && beats == restart_beat && !restarted) begin
          start     = 1'b1;
          restarted = 1;
        end
        out_ready = pick_ready(mode, cnt);
        if (wb_pending) begin
          regs[wb_beat] = 32'hDEAD;
          wb_pending    = 0;
        end
      end
    end

    if (!aborted) begin
      check("dump_finished", fin, 1);
      check("beat_count", beats, exp_beats);
      check("done_count", dones, 1);
      if (mode == 0) check("done_latency", done_cnt, 2 * N + 1 + CSUM_BEATS);
      check("stall_stable", stall_err, 0);
      check("busy_during_dump", busy_err, 0);
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (k > 0 && (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0)) idle_err++;
      end
      check("idle_after_done", idle_err, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) regs[i] = 32'h100 + i;
    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    #3;
    check("reset_valid", out_valid, 0);
    check("reset_last", out_last, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_data", out_data, 0);
    check("reset_addr", out_addr, 0);
    check("reset_rd_addr", rd_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_dump(0, -1, -1, -1);
    run_dump(1, -1, -1, -1);
    run_dump(0, 5, -1, -1);
    run_dump(0, -1, -1, 10);
    run_dump(0, -1, -1, -1);
    run_dump(0, -1, 3, -1);
    check("wb_reg3_updated", regs[3], 32'hDEAD);
    run_dump(0, -1, -1, -1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) regs[i] = $urandom;
      run_dump(2, $urandom_range(1, N - 2), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
